// File: rtl/sdram_pkg.sv
// Shared types for the SDRAM posted-write buffer: FSM states, the buffered
// write entry layout, the default FIFO depth and a byte-merge helper.
package sdram_pkg;

    localparam int WBUF_DEPTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE,
        WR_WAIT,
        RD_WAIT
    } wbuf_state_t;

    typedef struct packed {
        logic [26:2] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } wbuf_entry_t;

    // Replace the bytes of old_data selected by be with those of new_data.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_data,
                                                input logic [31:0] new_data,
                                                input logic [3:0]  be);
        logic [31:0] res;
        res = old_data;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) begin
                res[8*b +: 8] = new_data[8*b +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/sdram_wbuf_ram.sv
// Entry storage for the posted-write FIFO. One write port shared between a
// plain push and a tail read-modify-write merge; asynchronous head read;
// every entry's word address is exposed for the read-hazard comparator.
module sdram_wbuf_ram
    import sdram_pkg::*;
#(
    parameter int DEPTH = WBUF_DEPTH_DEFAULT
) (
    input  logic                     clk1x,
    input  logic                     push_en,
    input  logic [$clog2(DEPTH)-1:0] push_ptr,
    input  wbuf_entry_t              push_entry,
    input  logic                     merge_en,
    input  logic [$clog2(DEPTH)-1:0] merge_ptr,
    input  logic [31:0]              merge_data,
    input  logic [3:0]               merge_be,
    input  logic [$clog2(DEPTH)-1:0] head_ptr,
    output wbuf_entry_t              head_entry,
    output logic [26:2]              addr_vec [DEPTH]
);

    localparam int PW = $clog2(DEPTH);

    wbuf_entry_t   mem [DEPTH];
    wbuf_entry_t   tail_entry;
    wbuf_entry_t   merged_entry;
    wbuf_entry_t   wr_entry;
    logic [PW-1:0] wr_idx;
    logic          wr_en;

    assign tail_entry = mem[merge_ptr];

    // Build the merged tail entry: new bytes overwrite, enables accumulate.
    always_comb begin
        merged_entry      = tail_entry;
        merged_entry.data = merge_bytes(tail_entry.data, merge_data, merge_be);
        merged_entry.be   = tail_entry.be | merge_be;
    end

    assign wr_en    = push_en | merge_en;
    assign wr_idx   = push_en ? push_ptr : merge_ptr;
    assign wr_entry = push_en ? push_entry : merged_entry;

    // Single storage write port; contents need no reset since count gates validity.
    always_ff @(posedge clk1x) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_entry;
        end
    end

    assign head_entry = mem[head_ptr];

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_addr
        assign addr_vec[gi] = mem[gi].addr;
    end

endmodule

// File: rtl/sdram_wbuf.sv
// Posted-write buffer in front of SDRAM controller channel 2. Writes are
// queued so the requester never stalls; reads bypass the queue unless a
// buffered write targets the same word, in which case the queue drains first.
// Optional feature: define SDRAM_WBUF_COALESCE_EN to merge a write into the
// tail entry when it hits the same word address.
module sdram_wbuf
    import sdram_pkg::*;
#(
    parameter int DEPTH = WBUF_DEPTH_DEFAULT
) (
    input  logic        clk1x,
    input  logic        reset,
    input  logic        wr_req,
    input  logic [26:0] wr_addr,
    input  logic [31:0] wr_data,
    input  logic [3:0]  wr_be,
    output logic        wr_full,
    output logic        wr_ovf,
    input  logic        rd_req,
    input  logic [26:0] rd_addr,
    output logic        rd_busy,
    output logic        rd_done,
    output logic [31:0] rd_data,
    output logic        ram_req,
    output logic        ram_rnw,
    output logic [26:0] ram_addr,
    output logic [31:0] ram_din,
    output logic [3:0]  ram_be,
    input  logic        ram_ready,
    input  logic [31:0] ram_dout,
    input  logic        ram_idle
);

    localparam int          PW        = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT  = (PW+1)'(DEPTH);
    localparam logic [PW:0] DRAIN_CNT = (PW+1)'(DEPTH - 1);

    wbuf_state_t   state_reg, state_next;
    logic [PW-1:0] wr_ptr_reg, rd_ptr_reg, tail_ptr;
    logic [PW:0]   count_reg;
    logic          wr_ovf_reg, rd_busy_reg, rd_done_reg;
    logic [31:0]   rd_data_reg;
    logic [26:2]   rd_addr_reg;

    logic          push, pop, merge, rd_fire, rd_pending, hazard;
    logic [DEPTH-1:0] slot_hit;
    wbuf_entry_t   head_entry, push_entry;
    logic [26:2]   addr_vec [DEPTH];
    logic          unused_addr_lsbs;

    assign unused_addr_lsbs = ^{wr_addr[1:0], rd_addr[1:0]};

    assign wr_full = (count_reg == FULL_CNT);
    assign wr_ovf  = wr_ovf_reg;
    assign rd_busy = rd_busy_reg;
    assign rd_done = rd_done_reg;
    assign rd_data = rd_data_reg;

    // During the rd_done cycle rd_busy is still high but the read is complete.
    assign rd_pending = rd_busy_reg && !rd_done_reg;

    assign tail_ptr   = wr_ptr_reg - PW'(1);
    assign push_entry = '{addr: wr_addr[26:2], data: wr_data, be: wr_be};

`ifdef SDRAM_WBUF_COALESCE_EN
    logic head_busy;
    // The head is "in flight" from its issue cycle until ram_ready pops it.
    assign head_busy = (state_reg == WR_WAIT) ||
                       ((state_reg == IDLE) && (state_next == WR_WAIT));
    assign merge = wr_req && (count_reg != '0) &&
                   !((count_reg == (PW+1)'(1)) && head_busy) &&
                   (addr_vec[tail_ptr] == wr_addr[26:2]);
`else
    assign merge = 1'b0;
`endif

    // A full FIFO still accepts a push when the head pops in the same cycle.
    assign push = wr_req && !merge && (!wr_full || pop);

    sdram_wbuf_ram #(
        .DEPTH(DEPTH)
    ) u_ram (
        .clk1x      (clk1x),
        .push_en    (push),
        .push_ptr   (wr_ptr_reg),
        .push_entry (push_entry),
        .merge_en   (merge),
        .merge_ptr  (tail_ptr),
        .merge_data (wr_data),
        .merge_be   (wr_be),
        .head_ptr   (rd_ptr_reg),
        .head_entry (head_entry),
        .addr_vec   (addr_vec)
    );

    // Hazard comparator: an occupied slot (head included) matching the read word.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_hazard
        logic [PW-1:0] offset;
        assign offset       = PW'(gi) - rd_ptr_reg;
        assign slot_hit[gi] = ({1'b0, offset} < count_reg) &&
                              (addr_vec[gi] == rd_addr_reg);
    end
    assign hazard = rd_pending && (|slot_hit);

    // Next-state and channel outputs; reads win unless a buffered write aliases them.
    always_comb begin
        state_next = state_reg;
        ram_req    = 1'b0;
        ram_rnw    = 1'b1;
        ram_addr   = '0;
        ram_din    = '0;
        ram_be     = '0;
        pop        = 1'b0;
        rd_fire    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (rd_pending && !hazard) begin
                    ram_req    = 1'b1;
                    ram_addr   = {rd_addr_reg, 2'b00};
                    state_next = RD_WAIT;
                end else if ((count_reg != '0) &&
                             (ram_idle || (count_reg >= DRAIN_CNT) || hazard)) begin
                    ram_req    = 1'b1;
                    ram_rnw    = 1'b0;
                    ram_addr   = {head_entry.addr, 2'b00};
                    ram_din    = head_entry.data;
                    ram_be     = head_entry.be;
                    state_next = WR_WAIT;
                end
            end
            WR_WAIT: begin
                ram_rnw  = 1'b0;
                ram_addr = {head_entry.addr, 2'b00};
                ram_din  = head_entry.data;
                ram_be   = head_entry.be;
                if (ram_ready) begin
                    pop        = 1'b1;
                    state_next = IDLE;
                end
            end
            RD_WAIT: begin
                ram_addr = {rd_addr_reg, 2'b00};
                if (ram_ready) begin
                    rd_fire    = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // FSM state, FIFO pointers/occupancy and overflow flag.
    always_ff @(posedge clk1x) begin
        if (reset) begin
            state_reg  <= IDLE;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            wr_ovf_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            end
            if (push && !pop) begin
                count_reg <= count_reg + (PW+1)'(1);
            end else if (pop && !push) begin
                count_reg <= count_reg - (PW+1)'(1);
            end
            if (wr_req && wr_full && !pop && !merge) begin
                wr_ovf_reg <= 1'b1;
            end
        end
    end

    // Read capture, completion pulse and returned data.
    always_ff @(posedge clk1x) begin
        if (reset) begin
            rd_busy_reg <= 1'b0;
            rd_done_reg <= 1'b0;
            rd_data_reg <= '0;
            rd_addr_reg <= '0;
        end else begin
            rd_done_reg <= rd_fire;
            if (rd_fire) begin
                rd_data_reg <= ram_dout;
            end
            if (rd_done_reg) begin
                rd_busy_reg <= 1'b0;
            end else if (rd_req && !rd_busy_reg) begin
                rd_busy_reg <= 1'b1;
                rd_addr_reg <= rd_addr[26:2];
            end
        end
    end

endmodule

// File: tb/tb_sdram_wbuf.sv
// Scoreboard bench for sdram_wbuf: expected channel transactions and read
// data are queued as stimulus is driven, then popped as the DUT issues them.
module tb_sdram_wbuf;
    import sdram_pkg::*;

    typedef struct {
        logic        rnw;
        logic [26:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } txn_t;

    logic        clk1x = 1'b0;
    logic        reset;
    logic        wr_req;
    logic [26:0] wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_be;
    logic        wr_full, wr_ovf;
    logic        rd_req;
    logic [26:0] rd_addr;
    logic        rd_busy, rd_done;
    logic [31:0] rd_data;
    logic        ram_req, ram_rnw;
    logic [26:0] ram_addr;
    logic [31:0] ram_din;
    logic [3:0]  ram_be;
    logic        ram_ready;
    logic [31:0] ram_dout;
    logic        ram_idle;

    logic        auto_ready, force_ready, hold_off, pend;
    int          lat, wait_cnt, cyc, ready_cyc, n_req, full_cycles;
    logic [31:0] rd_resp;
    int          n_checks = 0;
    int          n_errors = 0;
    txn_t        exp_q [$];
    logic [31:0] rdq [$];

    always #5 clk1x = ~clk1x;
    assign ram_ready = auto_ready | force_ready;

    sdram_wbuf #(.DEPTH(8)) dut (
        .clk1x     (clk1x),
        .reset     (reset),
        .wr_req    (wr_req),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_be     (wr_be),
        .wr_full   (wr_full),
        .wr_ovf    (wr_ovf),
        .rd_req    (rd_req),
        .rd_addr   (rd_addr),
        .rd_busy   (rd_busy),
        .rd_done   (rd_done),
        .rd_data   (rd_data),
        .ram_req   (ram_req),
        .ram_rnw   (ram_rnw),
        .ram_addr  (ram_addr),
        .ram_din   (ram_din),
        .ram_be    (ram_be),
        .ram_ready (ram_ready),
        .ram_dout  (ram_dout),
        .ram_idle  (ram_idle)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk1x);
        #1;
    endtask

    task automatic wr(input logic [26:0] a, input logic [31:0] d, input logic [3:0] be);
        wr_req = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
        tick();
        wr_req = 1'b0;
    endtask

    task automatic push_wr(input logic [26:0] a, input logic [31:0] d, input logic [3:0] be);
        txn_t t;
        t.rnw = 1'b0; t.addr = a; t.data = d; t.be = be;
        exp_q.push_back(t);
    endtask

    task automatic post_wr(input logic [26:0] a, input logic [31:0] d, input logic [3:0] be);
        push_wr(a, d, be);
        wr(a, d, be);
    endtask

    task automatic push_rd(input logic [26:0] a, input logic [31:0] d);
        txn_t t;
        t.rnw = 1'b1; t.addr = a; t.data = '0; t.be = '0;
        exp_q.push_back(t);
        rdq.push_back(d);
    endtask

    task automatic rd(input logic [26:0] a, input logic [31:0] d);
        rd_resp = d;
        rd_req = 1'b1; rd_addr = a;
        tick();
        rd_req = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int max_cyc);
        int n = 0;
        while ((exp_q.size() != 0 || rdq.size() != 0 || dut.count_reg != 0 ||
                rd_busy || pend) && n < max_cyc) begin
            tick();
            n++;
        end
        check(tag, (n >= max_cyc), 1'b0);
    endtask

    // Channel model and monitor: checks issued transactions and read returns,
    // then answers each request with ram_ready after lat cycles.
    initial begin
        logic pend_before;
        txn_t e;
        auto_ready = 1'b0; ram_dout = '0; pend = 1'b0; wait_cnt = 0;
        cyc = 0; ready_cyc = 0; n_req = 0; full_cycles = 0;
        forever begin
            @(negedge clk1x);
            cyc++;
            auto_ready = 1'b0;
            if (reset) begin
                pend = 1'b0;
            end else begin
                pend_before = pend;
                if (wr_full) full_cycles++;
                if (rd_done) begin
                    $display("rd_done: data=0x%08h cyc=%0d", rd_data, cyc);
                    if (rdq.size() == 0) begin
                        check("rd_spurious", rd_done, 1'b0);
                    end else begin
                        check("rd_data", rd_data, rdq.pop_front());
                        check("rd_done_lat", cyc, ready_cyc + 1);
                        check("rd_busy_in_done", rd_busy, 1'b1);
                    end
                end
                if (pend && !hold_off) begin
                    if (wait_cnt <= 1) begin
                        auto_ready = 1'b1;
                        ram_dout   = rd_resp;
                        pend       = 1'b0;
                        ready_cyc  = cyc;
                    end else begin
                        wait_cnt--;
                    end
                end
                if (ram_req) begin
                    n_req++;
                    $display("ram txn %0d: rnw=%0b addr=0x%07h din=0x%08h be=%04b", n_req, ram_rnw, ram_addr, ram_din, ram_be);
                    check("req_overlap", pend_before, 1'b0);
                    if (exp_q.size() == 0) begin
                        check("req_spurious", ram_req, 1'b0);
                    end else begin
                        e = exp_q.pop_front();
                        check("txn_rnw", ram_rnw, e.rnw);
                        check("txn_addr", ram_addr, e.addr);
                        if (!e.rnw) begin
                            check("txn_din", ram_din, e.data);
                            check("txn_be", ram_be, e.be);
                        end
                    end
                    pend = 1'b1;
                    wait_cnt = lat;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int base_req, base_full;
        reset = 1'b1; wr_req = 0; wr_addr = 0; wr_data = 0; wr_be = 0;
        rd_req = 0; rd_addr = 0; ram_idle = 0; hold_off = 0; force_ready = 0;
        lat = 2; rd_resp = 0;
        repeat (3) tick();
        check("rst_wr_full", wr_full, 1'b0);
        check("rst_wr_ovf", wr_ovf, 1'b0);
        check("rst_rd_busy", rd_busy, 1'b0);
        check("rst_rd_done", rd_done, 1'b0);
        check("rst_rd_data", rd_data, 32'h0);
        check("rst_ram_req", ram_req, 1'b0);
        check("rst_ram_rnw", ram_rnw, 1'b1);
        check("rst_ram_addr", ram_addr, 27'h0);
        check("rst_ram_din_be", {ram_din, ram_be}, 36'h0);
        reset = 1'b0;
        tick();

        // Three ordered writes with the controller idle.
        ram_idle = 1'b1; lat = 2;
        base_req = n_req; base_full = full_cycles;
        post_wr(27'h100, 32'h1000_0000, 4'hF);
        check("t1_first_req", ram_req, 1'b1);
        post_wr(27'h104, 32'h1000_0001, 4'hF);
        post_wr(27'h108, 32'h1000_0002, 4'hF);
        wait_idle("t1_timeout", 60);
        check("t1_count", dut.count_reg, 0);
        check("t1_full_never", full_cycles - base_full, 0);
        check("t1_req_count", n_req - base_req, 3);

        // Pressure drain: nothing issues until seven entries are queued.
        ram_idle = 1'b0; lat = 1;
        for (int i = 0; i < 9; i++) begin
            post_wr(27'h1000 + 27'(4 * i), 32'hA000_0000 + 32'(i), 4'hF);
            if (i < 7) check("t2_drain_start", ram_req, (i == 6));
        end
        check("t2_no_ovf", wr_ovf, 1'b0);
        ram_idle = 1'b1;
        wait_idle("t2_timeout", 100);
        check("t2_count", dut.count_reg, 0);

        // Same burst with the controller stalled: the ninth write is dropped.
        hold_off = 1'b1; ram_idle = 1'b0; lat = 2;
        for (int i = 0; i < 9; i++) begin
            if (i < 8) push_wr(27'h2000 + 27'(4 * i), 32'hB000_0000 + 32'(i), 4'hF);
            wr(27'h2000 + 27'(4 * i), 32'hB000_0000 + 32'(i), 4'hF);
        end
        check("t2b_ovf", wr_ovf, 1'b1);
        check("t2b_full", wr_full, 1'b1);
        check("t2b_count", dut.count_reg, 8);
        hold_off = 1'b0; ram_idle = 1'b1;
        wait_idle("t2b_timeout", 100);
        check("t2b_ovf_sticky", wr_ovf, 1'b1);
        reset = 1'b1; tick(); tick(); reset = 1'b0;
        check("t2b_ovf_cleared", wr_ovf, 1'b0);

        // Read hazard: the aliasing write must reach SDRAM before the read.
        ram_idle = 1'b0; lat = 2;
        post_wr(27'h200, 32'hDEAD_BEEF, 4'hF);
        push_rd(27'h200, 32'h5A5A_1234);
        rd(27'h200, 32'h5A5A_1234);
        wait_idle("t3_timeout", 60);

        // Read bypass: unrelated buffered writes stay behind the read.
        ram_idle = 1'b0; lat = 2;
        wr(27'h300, 32'h3333_0000, 4'hF);
        wr(27'h304, 32'h3333_0001, 4'hF);
        push_rd(27'h400, 32'hC0FF_EE00);
        rd(27'h400, 32'hC0FF_EE00);
        check("t4_rd_req", ram_req, 1'b1);
        check("t4_rd_rnw", ram_rnw, 1'b1);
        check("t4_rd_addr", ram_addr, 27'h400);
        push_wr(27'h300, 32'h3333_0000, 4'hF);
        push_wr(27'h304, 32'h3333_0001, 4'hF);
        begin
            int n = 0;
            while (rd_busy && n < 50) begin tick(); n++; end
            check("t4_rd_timeout", (n >= 50), 1'b0);
        end
        check("t4_writes_held", dut.count_reg, 2);
        ram_idle = 1'b1;
        wait_idle("t4_timeout", 60);

        // Reset during WR_WAIT, then a stray ram_ready.
        hold_off = 1'b1; ram_idle = 1'b1; lat = 2;
        post_wr(27'h600, 32'h6666_6666, 4'hF);
        check("t5_req", ram_req, 1'b1);
        tick();
        check("t5_wr_wait", dut.state_reg, WR_WAIT);
        base_req = n_req;
        reset = 1'b1; tick(); reset = 1'b0;
        force_ready = 1'b1; tick(); force_ready = 1'b0;
        tick();
        check("t5_count", dut.count_reg, 0);
        check("t5_state", dut.state_reg, IDLE);
        check("t5_no_req", ram_req, 1'b0);
        check("t5_req_count", n_req - base_req, 0);
        check("t5_exp_empty", exp_q.size(), 0);
        hold_off = 1'b0;

        // Two writes to one word while the controller is busy.
        ram_idle = 1'b0; lat = 2;
        wr(27'h500, 32'h1122_3344, 4'b0011);
        wr(27'h500, 32'hAABB_CCDD, 4'b1100);
`ifdef SDRAM_WBUF_COALESCE_EN
        check("t6_count", dut.count_reg, 1);
        push_wr(27'h500, 32'hAABB_3344, 4'b1111);
`else
        check("t6_count", dut.count_reg, 2);
        push_wr(27'h500, 32'h1122_3344, 4'b0011);
        push_wr(27'h500, 32'hAABB_CCDD, 4'b1100);
`endif
        ram_idle = 1'b1;
        wait_idle("t6_timeout", 60);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
